pos_cache_reader: RTL and testbench

- Downstream consumer of one cell's position cache; walks the active buffer and streams its particles to the force-evaluation filters.
- Reads address 0 for the particle count, then reads addresses 1..N and emits one particle per handshake with an id and a last flag.
- Absorbs the cache's 1-cycle read latency and downstream backpressure with a small output FIFO.
- Aborts cleanly when a motion update starts, because the cache swaps buffers then.

---
 rtl/pos_cache_reader_pkg.sv | 27 ++
 rtl/pos_reader_fifo.sv | 69 ++++++
 rtl/pos_cache_reader.sv | 193 +++++++++++++++++++
 tb/tb_pos_cache_reader.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pos_cache_reader_pkg.sv
// Shared definitions for the position-cache reader: controller states and
// the {posz,posy,posx} particle word layout.
package pos_cache_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_NUM   = 3'd1,
    ST_WAIT_NUM = 3'd2,
    ST_STREAM   = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  typedef enum int {
    AXIS_X = 0,
    AXIS_Y = 1,
    AXIS_Z = 2
  } axis_e;

  localparam int POS_AXES = 3;

  // LSB of one coordinate field inside a particle word.
  function automatic int pos_field_lsb(input int axis, input int data_width);
    return axis * data_width;
  endfunction

endpackage

// File: rtl/pos_reader_fifo.sv
// Small synchronous FIFO with show-ahead head, occupancy count and a
// single-cycle flush that wins over a simultaneous push.
module pos_reader_fifo #(
  parameter int WIDTH = 105,
  parameter int DEPTH = 4,
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [OCC_W-1:0] occupancy,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    do_pop   = pop && (occ_q != '0);
    do_push  = push && ((occ_q != OCC_W'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push && !do_pop) occ_d = occ_q + OCC_W'(1);
      if (!do_push && do_pop) occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign occupancy = occ_q;
  assign empty     = (occ_q == '0);

endmodule

// File: rtl/pos_cache_reader.sv
// Walks one cell's position cache (count at address 0, particles at 1..N)
// and streams the particles downstream through a small output FIFO.
module pos_cache_reader
  import pos_cache_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        motion_update_enable,
  output logic                        out_rden,
  output logic [ADDR_WIDTH-1:0]       out_rd_addr,
  input  logic [3*DATA_WIDTH-1:0]     in_particle_info,
  input  logic                        in_ready,
  output logic                        out_particle_valid,
  output logic [3*DATA_WIDTH-1:0]     out_particle_data,
  output logic [ADDR_WIDTH-1:0]       out_particle_id,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done,
  output logic                        abort,
  output logic                        count_err
);

  localparam int PW      = POS_AXES * DATA_WIDTH;
  localparam int ENTRY_W = PW + ADDR_WIDTH + 1;
  localparam int OCC_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] MAX_CNT     = ADDR_WIDTH'(PARTICLE_NUM);
  localparam logic [OCC_W:0]        ISSUE_LIMIT = (OCC_W + 1)'(FIFO_DEPTH - 2);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
  logic                  out_rden_q, out_rden_d;
  logic [ADDR_WIDTH-1:0] out_rd_addr_q, out_rd_addr_d;
  logic                  pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] pend_id_q, pend_id_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  abort_q, abort_d;
  logic                  count_err_q, count_err_d;

  logic [ENTRY_W-1:0]    fifo_push_data, fifo_head;
  logic [OCC_W-1:0]      fifo_occ;
  logic                  fifo_empty, fifo_pop, head_valid;
  logic                  abort_now, issue_ok, drain_empty;
  logic [OCC_W:0]        inflight;
  logic [ADDR_WIDTH-1:0] cnt_raw;

  assign head_valid = !fifo_empty;
  assign fifo_pop   = head_valid && in_ready;
  assign abort_now  = (state_q != ST_IDLE) && motion_update_enable;
  assign cnt_raw    = in_particle_info[ADDR_WIDTH-1:0];

  // The read on the bus this cycle lands in the FIFO one cycle later; the
  // returning word is pushed this edge, so it is not counted against headroom.
  assign inflight    = {1'b0, fifo_occ} + {{OCC_W{1'b0}}, out_rden_q};
  assign issue_ok    = (inflight <= ISSUE_LIMIT);
  assign drain_empty = !out_rden_q && !pend_q &&
                       ((fifo_occ == '0) || ((fifo_occ == OCC_W'(1)) && fifo_pop));

  assign fifo_push_data = {(pend_id_q == count_q), pend_id_q, in_particle_info};

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    next_addr_d   = next_addr_q;
    out_rden_d    = 1'b0;
    out_rd_addr_d = out_rd_addr_q;
    pend_d        = out_rden_q && (out_rd_addr_q != '0);
    pend_id_d     = out_rd_addr_q;
    done_d        = 1'b0;
    abort_d       = 1'b0;
    count_err_d   = count_err_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !motion_update_enable) begin
          state_d       = ST_RD_NUM;
          out_rden_d    = 1'b1;
          out_rd_addr_d = '0;
        end
      end
      ST_RD_NUM: state_d = ST_WAIT_NUM;
      ST_WAIT_NUM: begin
        if (cnt_raw > MAX_CNT) begin
          count_err_d = 1'b1;
          count_d     = MAX_CNT;
        end else begin
          count_d = cnt_raw;
        end
        if (count_d == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          out_rden_d    = 1'b1;
          out_rd_addr_d = ADDR_WIDTH'(1);
          next_addr_d   = ADDR_WIDTH'(2);
          state_d       = (count_d == ADDR_WIDTH'(1)) ? ST_DRAIN : ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (issue_ok) begin
          out_rden_d    = 1'b1;
          out_rd_addr_d = next_addr_q;
          next_addr_d   = next_addr_q + ADDR_WIDTH'(1);
          if (next_addr_q == count_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_empty) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    // A motion update swaps the cache buffers, so everything in flight is stale.
    if (abort_now) begin
      state_d    = ST_IDLE;
      out_rden_d = 1'b0;
      pend_d     = 1'b0;
      done_d     = 1'b0;
      busy_d     = 1'b0;
      abort_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      next_addr_q   <= '0;
      out_rden_q    <= 1'b0;
      out_rd_addr_q <= '0;
      pend_q        <= 1'b0;
      pend_id_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      abort_q       <= 1'b0;
      count_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      next_addr_q   <= next_addr_d;
      out_rden_q    <= out_rden_d;
      out_rd_addr_q <= out_rd_addr_d;
      pend_q        <= pend_d;
      pend_id_q     <= pend_id_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      abort_q       <= abort_d;
      count_err_q   <= count_err_d;
    end
  end

  pos_reader_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH),
    .OCC_W (OCC_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort_now),
    .push      (pend_q),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .occupancy (fifo_occ),
    .empty     (fifo_empty)
  );

  for (genvar gi = 0; gi < POS_AXES; gi++) begin : g_axis
    assign out_particle_data[pos_field_lsb(gi, DATA_WIDTH) +: DATA_WIDTH] =
      head_valid ? fifo_head[pos_field_lsb(gi, DATA_WIDTH) +: DATA_WIDTH] : '0;
  end

  assign out_particle_valid = head_valid;
  assign out_particle_id    = head_valid ? fifo_head[PW +: ADDR_WIDTH] : '0;
  assign out_last           = head_valid && fifo_head[ENTRY_W-1];
  assign out_rden           = out_rden_q;
  assign out_rd_addr        = out_rd_addr_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign abort              = abort_q;
  assign count_err          = count_err_q;

endmodule

// File: tb/tb_pos_cache_reader.sv
// Randomized bench: a cache memory model answers reads one cycle late and a
// per-pass expectation (ids 1..min(count,220), sticky count error) checks the stream.
module tb_pos_cache_reader;

  localparam int DW = 32;
  localparam int PN = 220;
  localparam int AW = 8;
  localparam int FD = 4;
  localparam int PW = 3 * DW;

  logic          clk = 1'b0;
  logic          rst, start, mue, in_ready;
  logic          out_rden, out_particle_valid, out_last, busy, done, abort, count_err;
  logic [AW-1:0] out_rd_addr, out_particle_id;
  logic [PW-1:0] in_particle_info, out_particle_data;

  logic [PW-1:0] cache_mem [256];
  int            tests_run = 0;
  int            tests_failed = 0;
  bit            err_model = 1'b0;

  always #5 clk = ~clk;

  // Cache: data for the address presented in a cycle appears the next cycle.
  always @(posedge clk)
    in_particle_info <= out_rden ? cache_mem[out_rd_addr] : {$urandom, $urandom, $urandom};

  pos_cache_reader dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .motion_update_enable (mue),
    .out_rden             (out_rden),
    .out_rd_addr          (out_rd_addr),
    .in_particle_info     (in_particle_info),
    .in_ready             (in_ready),
    .out_particle_valid   (out_particle_valid),
    .out_particle_data    (out_particle_data),
    .out_particle_id      (out_particle_id),
    .out_last             (out_last),
    .busy                 (busy),
    .done                 (done),
    .abort                (abort),
    .count_err            (count_err)
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input bit err_exp);
    check_val("zero_rden", out_rden, 0);
    check_val("zero_addr", out_rd_addr, 0);
    check_val("zero_valid", out_particle_valid, 0);
    check_val("zero_data", out_particle_data, 0);
    check_val("zero_id", out_particle_id, 0);
    check_val("zero_last", out_last, 0);
    check_val("zero_busy", busy, 0);
    check_val("zero_done", done, 0);
    check_val("zero_abort", abort, 0);
    check_val("zero_count_err", count_err, err_exp);
  endtask

  // kill_mode: 0 none, 1 motion update after kill_after pops, 2 reset after kill_after pops
  task automatic run_pass(input int raw, input int ready_mode, input int kill_mode,
                          input int kill_after, input bit timing);
    int            n, cyc, exp_id, exp_addr, popped, issued;
    bit            finished, rdy, pv, pr;
    logic [PW-1:0] pd;
    logic [AW-1:0] pi;
    for (int i = 1; i < 256; i++) cache_mem[i] = {$urandom, $urandom, $urandom};
    pd = {$urandom, $urandom, $urandom};
    pd[AW-1:0] = AW'(raw);
    cache_mem[0] = pd;
    n = (raw > PN) ? PN : raw;
    if (raw > PN) err_model = 1'b1;
    start = 1'b1;
    in_ready = 1'b1;
    step();
    start = 1'b0;
    cyc = 1; exp_id = 1; exp_addr = 1; popped = 0; issued = 0;
    finished = 1'b0; pv = 1'b0; pr = 1'b0; pi = '0;
    while (!finished && cyc < 2000) begin
      if (timing && cyc == 1) begin
        check_val("c1_rden", out_rden, 1);
        check_val("c1_addr", out_rd_addr, 0);
        check_val("c1_busy", busy, 1);
      end
      if (timing && cyc == 3) begin
        check_val("c3_rden", out_rden, (n > 0) ? 1 : 0);
        if (n > 0) check_val("c3_addr", out_rd_addr, 1);
      end
      if (out_rden && out_rd_addr != 0) begin
        issued++;
        check_val("rd_addr", out_rd_addr, exp_addr);
        check_val("rd_in_range", (int'(out_rd_addr) <= n), 1);
        check_val("inflight_le_depth", ((issued - popped) <= FD), 1);
        exp_addr++;
      end
      if (pv && !pr) begin
        check_val("stall_valid", out_particle_valid, 1);
        check_val("stall_data", out_particle_data, pd);
        check_val("stall_id", out_particle_id, pi);
      end
      if (kill_mode != 0 && popped == kill_after) begin
        in_ready = 1'b0;
        if (kill_mode == 1) begin
          mue = 1'b1;
          start = 1'b1;
          step();
          check_val("abort_pulse", abort, 1);
          check_val("abort_valid", out_particle_valid, 0);
          check_val("abort_rden", out_rden, 0);
          check_val("abort_busy", busy, 0);
          check_val("abort_no_done", done, 0);
          for (int k = 0; k < 3; k++) begin
            step();
            check_val("mue_start_ignored", busy, 0);
            check_val("mue_no_valid", out_particle_valid, 0);
            check_val("abort_once", abort, 0);
          end
          start = 1'b0;
          mue = 1'b0;
          step();
        end else begin
          rst = 1'b1;
          step();
          rst = 1'b0;
          err_model = 1'b0;
          check_all_zero(1'b0);
        end
        $display("[TB] pass raw=%0d killed mode=%0d after %0d particles", raw, kill_mode, popped);
        return;
      end
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      in_ready = rdy;
      if (out_particle_valid && rdy) begin
        check_val("id", out_particle_id, exp_id);
        check_val("data", out_particle_data, cache_mem[exp_id]);
        check_val("last", out_last, (exp_id == n) ? 1 : 0);
        if (timing) check_val("valid_cycle", cyc, 4 + exp_id);
        exp_id++;
        popped++;
      end
      pv = out_particle_valid; pr = rdy; pd = out_particle_data; pi = out_particle_id;
      if (done) begin
        check_val("all_streamed", exp_id, n + 1);
        check_val("count_err", count_err, err_model);
        check_val("busy_in_done", busy, 1);
        if (timing) check_val("done_cycle", cyc, (n == 0) ? 3 : 5 + n);
        finished = 1'b1;
      end
      step();
      cyc++;
    end
    if (!finished) begin
      check_val("timeout", 0, 1);
    end else begin
      check_val("busy_after_done", busy, 0);
      check_val("done_one_cycle", done, 0);
    end
    $display("[TB] pass raw=%0d streamed=%0d cycles=%0d", raw, exp_id - 1, cyc);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mue = 1'b0; in_ready = 1'b1;
    step();
    step();
    check_all_zero(1'b0);
    rst = 1'b0;
    step();
    run_pass(3, 0, 0, 0, 1'b1);
    run_pass(0, 0, 0, 0, 1'b1);
    run_pass(8, 1, 0, 0, 1'b0);
    run_pass(250, 2, 0, 0, 1'b0);
    run_pass(5, 2, 0, 0, 1'b0);
    run_pass(6, 0, 1, 2, 1'b0);
    run_pass(4, 0, 0, 0, 1'b1);
    run_pass(10, 0, 2, 2, 1'b0);
    run_pass(3, 0, 0, 0, 1'b1);
    for (int k = 0; k < 5; k++) run_pass(int'($urandom_range(1, 40)), 2, 0, 0, 1'b0);
    run_pass(1, 0, 0, 0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
